int_ctrl: RTL
=============

INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 Parameter NUM_CH, default 15: number of interrupt channels, legal range 1..15.
REQ-002 Parameter VEC_W, default 4: VECTOR width; NUM_CH SHALL be at most 2**VEC_W-1, checked at elaboration.
REQ-003 Parameter DATA_W, default 18: register data width; NUM_CH SHALL be at most DATA_W.
REQ-004 Parameter SYNC_STAGES, default 2: IRQ synchronizer depth, legal range 1..3.
REQ-005 CLK  in  1  single system clock; all state on rising edge.
REQ-006 RESET_N  in  1  reset, synchronous to CLK, active low.
REQ-007 IRQ  in  NUM_CH  asynchronous interrupt requests; bit n = channel n.
REQ-008 SEL  in  1  port access to this block (decoded by top level from ADRS).
REQ-009 REG_ADRS  in  2  register select: 0 PEND, 1 MASK, 2 MODE, 3 SWI.
REQ-010 PORT_WR  in  1  write strobe, qualified by SEL.
REQ-011 PORT_RD  in  1  read strobe, qualified by SEL.
REQ-012 DIN  in  DATA_W  write data (core DATAOUT).
REQ-013 DOUT  out  DATA_W  read data to core DATAIN.
REQ-014 VECTOR  out  VEC_W  to core VECTOR; 0 = no request, n+1 = channel n.
REQ-015 IRQ_ANY  out  1  high when any unmasked request is pending.

Function
REQ-016 IRQ SHALL pass through SYNC_STAGES flops before any use.
REQ-017 MODE bit n = 1: channel n is edge mode; PEND[n] sets on a synchronized 0->1 transition and holds until cleared.
REQ-018 MODE bit n = 0: channel n is level mode; PEND[n] follows the synchronized level each cycle; W1C has no lasting effect.
REQ-019 Write PEND: write-1-to-clear; bits written 0 unchanged.
REQ-020 Write SWI: write-1-to-set PEND bits (software interrupt), all modes; SWI reads as 0.
REQ-021 Same-cycle edge set and W1C on one channel: set wins; PEND stays 1.
REQ-022 Same-cycle SWI set and edge set: PEND is 1, no double count.
REQ-023 Write MASK/MODE: load DIN[NUM_CH-1:0]; MASK bit 1 = channel enabled.
REQ-024 Writing MODE SHALL clear PEND bits whose mode changes, the same cycle.
REQ-025 Register bits at or above NUM_CH SHALL read 0 and ignore writes.
REQ-026 Priority: highest channel index among PEND & MASK wins; VECTOR = winner+1, else 0.
REQ-027 VECTOR and IRQ_ANY SHALL be registered; latency from a PEND/MASK change to VECTOR = 1 cycle; synchronized IRQ edge to VECTOR = SYNC_STAGES+2 cycles.
REQ-028 VECTOR SHALL stay stable while the winner is unchanged; it changes only on PEND/MASK update.
REQ-029 Read: DOUT registered, valid the cycle after SEL & PORT_RD; otherwise DOUT = 0.
REQ-030 Read PEND returns raw PEND (unmasked); reading has no side effect.
REQ-031 SEL & PORT_WR & PORT_RD in the same cycle: write performed, read returns pre-write value.

Reset
REQ-032 With RESET_N low at a rising edge: PEND, MASK, MODE, synchronizer flops, edge history, DOUT, VECTOR, IRQ_ANY all 0.
REQ-033 Reset mid-operation SHALL discard pending edges; an IRQ held high through reset SHALL NOT produce an edge at release; level-mode channels pend after SYNC_STAGES cycles.
REQ-034 All writes SHALL be ignored while RESET_N is low.

Structure
REQ-035 Register address constants (PEND/MASK/MODE/SWI) and VEC_W default SHALL live in the shared Core18 package.
REQ-036 Priority encoder SHALL be a sub-module, int_prio_enc, combinational, parameterised by NUM_CH and VEC_W.

Verification
REQ-037 MODE=all edge, MASK=0x7FFF, pulse IRQ[4] 1 cycle -> VECTOR=5 after SYNC_STAGES+2 cycles, held until W1C PEND bit4 -> VECTOR=0 next cycle.
REQ-038 PEND bits 2 and 9 set, MASK=0x7FFF -> VECTOR=10; clear MASK[9] -> VECTOR=3 next cycle; read PEND -> DOUT=0o1004.
REQ-039 Level channel 0, IRQ[0] held high, W1C PEND bit0 -> VECTOR stays 1; drop IRQ[0] -> VECTOR=0 after SYNC_STAGES+1 cycles.
REQ-040 Edge on IRQ[7] arriving the same cycle as W1C bit7 -> PEND[7]=1, VECTOR=8.
REQ-041 SWI write 0x0020, MASK=0 -> PEND=0x0020, VECTOR=0, IRQ_ANY=0; MASK=0x0020 -> VECTOR=6; assert RESET_N=0 one cycle -> all outputs 0.
REQ-042 With Core18 running a level-3 task, VECTOR=5 injected during a skip opcode -> ISR taken, RTI resumes at the correct skipped/non-skipped PC.

Source files
------------

// File: rtl/int_ctrl_pkg.sv
// Shared Core18 definitions used by the interrupt controller: register map
// and default vector width.
package int_ctrl_pkg;

  localparam int CORE18_VEC_W = 4;

  typedef enum logic [1:0] {
    REG_PEND = 2'd0,
    REG_MASK = 2'd1,
    REG_MODE = 2'd2,
    REG_SWI  = 2'd3
  } reg_sel_e;

endpackage

// File: rtl/int_prio_enc.sv
// Combinational priority encoder: the highest set request index wins and is
// reported as index+1; zero means no request.
module int_prio_enc #(
  parameter int NUM_CH = 15,
  parameter int VEC_W  = 4
) (
  input  logic [NUM_CH-1:0] req,
  output logic [VEC_W-1:0]  vec
);

  // ascending scan so the last (highest) set bit overrides lower ones
  always_comb begin
    vec = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (req[i]) begin
        vec = VEC_W'(i + 1);
      end else begin
        vec = vec;
      end
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// Core18 interrupt controller: synchronized IRQ inputs, per-channel edge/level
// mode, pend/mask/software-interrupt registers and a registered vector output.
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int NUM_CH      = 15,
  parameter int VEC_W       = CORE18_VEC_W,
  parameter int DATA_W      = 18,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] irq,
  input  logic              sel,
  input  logic [1:0]        reg_adrs,
  input  logic              port_wr,
  input  logic              port_rd,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic [VEC_W-1:0]  vector,
  output logic              irq_any
);

  if (NUM_CH < 1 || NUM_CH > 15 || NUM_CH > (2 ** VEC_W) - 1 || NUM_CH > DATA_W ||
      SYNC_STAGES < 1 || SYNC_STAGES > 3) begin : g_param_err
    $error("int_ctrl: illegal parameter combination");
  end

  logic [NUM_CH-1:0]      sync_r [SYNC_STAGES];
  logic [NUM_CH-1:0]      prev_r;
  logic [NUM_CH-1:0]      pend_r;
  logic [NUM_CH-1:0]      mask_r;
  logic [NUM_CH-1:0]      mode_r;
  logic [SYNC_STAGES:0]   armed_r;
  logic [DATA_W-1:0]      dout_r;
  logic [VEC_W-1:0]       vector_r;
  logic                   irq_any_r;

  logic [NUM_CH-1:0]      irq_sync_s;
  logic [NUM_CH-1:0]      edge_s;
  logic [NUM_CH-1:0]      pend_view_s;
  logic [NUM_CH-1:0]      active_s;
  logic [NUM_CH-1:0]      w1c_s;
  logic [NUM_CH-1:0]      swi_s;
  logic [NUM_CH-1:0]      mode_chg_s;
  logic [NUM_CH-1:0]      pend_nxt_s;
  logic [NUM_CH-1:0]      rd_val_s;
  logic                   mask_wr_s;
  logic                   mode_wr_s;
  logic [VEC_W-1:0]       vec_s;
  logic                   unused_s;

  assign unused_s   = ^din;
  assign irq_sync_s = sync_r[SYNC_STAGES-1];

  // Edges are only trusted once the history flop holds a post-reset sample,
  // so an IRQ held high through reset does not look like a fresh edge.
  assign edge_s      = irq_sync_s & ~prev_r & mode_r & {NUM_CH{armed_r[SYNC_STAGES]}};
  // Level channels expose the synchronized input directly; pend_r only
  // carries a one-cycle software set for them.
  assign pend_view_s = pend_r | (irq_sync_s & ~mode_r);
  assign active_s    = pend_view_s & mask_r;

  // register write decode and pend next-state
  always_comb begin
    w1c_s     = '0;
    swi_s     = '0;
    mask_wr_s = 1'b0;
    mode_wr_s = 1'b0;
    if (sel && port_wr) begin
      case (reg_sel_e'(reg_adrs))
        REG_PEND: w1c_s     = din[NUM_CH-1:0];
        REG_MASK: mask_wr_s = 1'b1;
        REG_MODE: mode_wr_s = 1'b1;
        REG_SWI:  swi_s     = din[NUM_CH-1:0];
        default:  w1c_s     = '0;
      endcase
    end else begin
      w1c_s = '0;
    end
    if (mode_wr_s) begin
      mode_chg_s = din[NUM_CH-1:0] ^ mode_r;
    end else begin
      mode_chg_s = '0;
    end
    pend_nxt_s = ((((pend_r & ~w1c_s) | edge_s) & mode_r) | swi_s) & ~mode_chg_s;
  end

  // read data mux (pre-write values)
  always_comb begin
    rd_val_s = '0;
    case (reg_sel_e'(reg_adrs))
      REG_PEND: rd_val_s = pend_view_s;
      REG_MASK: rd_val_s = mask_r;
      REG_MODE: rd_val_s = mode_r;
      REG_SWI:  rd_val_s = '0;
      default:  rd_val_s = '0;
    endcase
  end

  int_prio_enc #(
    .NUM_CH (NUM_CH),
    .VEC_W  (VEC_W)
  ) u_prio_enc (
    .req (active_s),
    .vec (vec_s)
  );

  // all controller state
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_r[i] <= '0;
      end
      prev_r    <= '0;
      armed_r   <= '0;
      pend_r    <= '0;
      mask_r    <= '0;
      mode_r    <= '0;
      dout_r    <= '0;
      vector_r  <= '0;
      irq_any_r <= 1'b0;
    end else begin
      sync_r[0] <= irq;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
      prev_r  <= irq_sync_s;
      armed_r <= {armed_r[SYNC_STAGES-1:0], 1'b1};
      pend_r  <= pend_nxt_s;
      if (mask_wr_s) begin
        mask_r <= din[NUM_CH-1:0];
      end
      if (mode_wr_s) begin
        mode_r <= din[NUM_CH-1:0];
      end
      dout_r    <= (sel && port_rd) ? DATA_W'(rd_val_s) : '0;
      vector_r  <= vec_s;
      irq_any_r <= |active_s;
    end
  end

  assign dout    = dout_r;
  assign vector  = vector_r;
  assign irq_any = irq_any_r;

endmodule
